// File: rtl/mlp_score_argmax_capture_if.sv
// Score-in / result-out channel bundle for the MLP output-layer argmax capture.
// No storage; pure wiring between the score producer, the capture block and the result consumer.
// Backpressure: out_ready from the consumer; busy tells the producer a new vector is not taken.
interface mlp_score_argmax_capture_if #(
   parameter int DATA_W  = 16,
   parameter int N_CLASS = 10
);
   localparam int CLS_W = $clog2(N_CLASS);

   logic                        score_valid;
   logic [N_CLASS*DATA_W-1:0]   score_in;
   logic                        busy;
   logic                        out_valid;
   logic                        out_ready;
   logic [CLS_W-1:0]            out_class;
   logic [DATA_W-1:0]           out_score;

   // Producer/consumer side
   modport master (
      output score_valid, score_in, out_ready,
      input  busy, out_valid, out_class, out_score
   );

   // Capture block side
   modport slave (
      input  score_valid, score_in, out_ready,
      output busy, out_valid, out_class, out_score
   );
endinterface

// File: rtl/mlp_score_argmax_capture.sv
// Latches N_CLASS signed scores per image, scans for the argmax and queues {class, score} results.
// Latency: result visible the cycle after edge T+N_CLASS (T = accepting edge); busy for N_CLASS cycles.
// Backpressure: valid/ready result FIFO of DEPTH entries; a result arriving at a full FIFO is dropped.
module mlp_score_argmax_capture #(
   parameter int DATA_W  = 16,
   parameter int N_CLASS = 10,
   parameter int DEPTH   = 16,
   parameter int CNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   mlp_score_argmax_capture_if.slave   bus,
   input  logic [$clog2(N_CLASS)-1:0]  rd_sel,
   output logic [DATA_W-1:0]           rd_score,
   output logic [CNT_W-1:0]            img_count,
   output logic                        err_overflow,
   output logic                        err_busy_drop
);
   localparam int CLS_W = $clog2(N_CLASS);
   localparam int AW    = $clog2(DEPTH);
   localparam logic [CLS_W-1:0] LAST_IDX = CLS_W'(N_CLASS - 1);

   typedef enum logic [1:0] {IDLE, SCAN, PUSH} state_t;

   state_t state, state_nxt;

   // Latched vector and scan registers
   logic signed [DATA_W-1:0] vec [N_CLASS];
   logic signed [DATA_W-1:0] best;
   logic [CLS_W-1:0]         best_idx;
   logic [CLS_W-1:0]         idx;

   // Result FIFO
   logic [CLS_W+DATA_W-1:0]  mem [DEPTH];
   logic [AW-1:0]            wr_ptr, rd_ptr;
   logic [AW:0]              count;
   logic                     push, pop, full, wr_en, drop;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state: accept in IDLE, walk all classes in SCAN, one cycle to enqueue
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.score_valid) state_nxt = SCAN;
         SCAN:    if (idx == LAST_IDX) state_nxt = PUSH;
         PUSH:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Capture the vector and track the running maximum; strict '>' keeps the lowest index on ties
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < N_CLASS; k++) vec[k] <= '0;
         best     <= '0;
         best_idx <= '0;
         idx      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.score_valid) begin
                  for (int k = 0; k < N_CLASS; k++) vec[k] <= bus.score_in[k*DATA_W +: DATA_W];
                  best     <= bus.score_in[0 +: DATA_W];
                  best_idx <= '0;
                  idx      <= CLS_W'(1);
               end
            end
            SCAN: begin
               if (vec[idx] > best) begin
                  best     <= vec[idx];
                  best_idx <= idx;
               end
               if (idx != LAST_IDX) idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign push  = (state == PUSH);
   assign pop   = bus.out_valid && bus.out_ready;
   assign full  = (count == (AW+1)'(DEPTH));
   // At full, a simultaneous pop frees the slot being written
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   // FIFO storage; the write during reset is suppressed so a reset mid-PUSH leaves nothing behind
   always_ff @(posedge clk) begin
      if (rst && wr_en) mem[wr_ptr] <= {best_idx, best};
   end

   // FIFO pointers, occupancy and the classified-image counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         img_count <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr    <= wr_ptr + 1'b1;
            img_count <= img_count + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_overflow  <= 1'b0;
         err_busy_drop <= 1'b0;
      end else begin
         if (drop)                                 err_overflow  <= 1'b1;
         if (bus.score_valid && (state != IDLE))   err_busy_drop <= 1'b1;
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = (count != '0);
   assign bus.out_class = bus.out_valid ? mem[rd_ptr][DATA_W +: CLS_W] : '0;
   assign bus.out_score = bus.out_valid ? mem[rd_ptr][0 +: DATA_W]     : '0;

   // Readback of the last latched vector; out-of-range selects read as zero
   always_comb begin
      rd_score = '0;
      if ({1'b0, rd_sel} < (CLS_W+1)'(N_CLASS)) rd_score = vec[rd_sel];
   end
endmodule

// File: tb/tb_mlp_score_argmax_capture.sv
// Randomised and directed bench for mlp_score_argmax_capture with a queue-based scoreboard.
// Expected {class, score} results come from a plain argmax over the stimulus vector.
// A monitor compares every handshaked FIFO head against the queue front.
module tb_mlp_score_argmax_capture;
   localparam int DATA_W = 16;
   localparam int N      = 10;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 16;
   localparam int CLS_W  = $clog2(N);
   localparam int VW     = N * DATA_W;

   logic              clk = 1'b0;
   logic              rst;
   logic [CLS_W-1:0]  rd_sel;
   logic [DATA_W-1:0] rd_score;
   logic [CNT_W-1:0]  img_count;
   logic              err_overflow;
   logic              err_busy_drop;

   mlp_score_argmax_capture_if #(.DATA_W(DATA_W), .N_CLASS(N)) bus ();

   mlp_score_argmax_capture #(.DATA_W(DATA_W), .N_CLASS(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .rd_sel       (rd_sel),
      .rd_score     (rd_score),
      .img_count    (img_count),
      .err_overflow (err_overflow),
      .err_busy_drop(err_busy_drop)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int pops   = 0;
   int rdy_mode = 0;          // 0 low, 1 random, 2 high, 3 follow rdy_manual
   logic rdy_manual = 1'b0;
   logic [CNT_W-1:0] exp_img = '0;
   logic [CLS_W+DATA_W-1:0] exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: index of the largest signed score, lowest index on ties
   function automatic logic [CLS_W+DATA_W-1:0] ref_argmax(input logic [VW-1:0] v);
      int b = 0;
      for (int k = 1; k < N; k++)
         if ($signed(v[k*DATA_W +: DATA_W]) > $signed(v[b*DATA_W +: DATA_W])) b = k;
      return {CLS_W'(b), v[b*DATA_W +: DATA_W]};
   endfunction

   // mode 0: expect a result if the model FIFO has room; 1: always expect; 2: expect nothing
   task automatic strobe(input logic [VW-1:0] v, input int mode);
      if (mode == 1 || (mode == 0 && exp_q.size() < DEPTH)) begin
         exp_q.push_back(ref_argmax(v));
         exp_img++;
      end
      bus.score_in    = v;
      bus.score_valid = 1'b1;
      @(posedge clk); #1;
      bus.score_valid = 1'b0;
   endtask

   task automatic send(input logic [VW-1:0] v);
      strobe(v, 0);
      repeat (N) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      rdy_mode = 2;
      for (int i = 0; i < 400 && (exp_q.size() != 0 || bus.out_valid); i++) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("drain_left", 64'(exp_q.size()), 64'd0);
      check("drain_valid", 64'(bus.out_valid), 64'd0);
      rdy_mode = 0;
      @(posedge clk); #1;
   endtask

   function automatic logic [VW-1:0] fill(input logic [DATA_W-1:0] x);
      logic [VW-1:0] v;
      for (int k = 0; k < N; k++) v[k*DATA_W +: DATA_W] = x;
      return v;
   endfunction

   // Ready driver
   always begin
      @(posedge clk); #1;
      case (rdy_mode)
         0:       bus.out_ready = 1'b0;
         1:       bus.out_ready = 1'($urandom_range(0, 1));
         2:       bus.out_ready = 1'b1;
         default: bus.out_ready = rdy_manual;
      endcase
   end

   // Monitor: every accepted head must match the oldest expected result
   always @(negedge clk) begin
      if (rst && bus.out_valid && bus.out_ready) begin
         pops++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got class %0d score %0h expected none", bus.out_class, bus.out_score);
         end else begin
            logic [CLS_W+DATA_W-1:0] e;
            e = exp_q.pop_front();
            check("out_class", 64'(bus.out_class), 64'(e[DATA_W +: CLS_W]));
            check("out_score", 64'(bus.out_score), 64'(e[0 +: DATA_W]));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [VW-1:0] v, v2;
      int p0;
      rst = 1'b0;
      rd_sel = '0;
      bus.score_valid = 1'b0;
      bus.score_in = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_class", 64'(bus.out_class), 64'd0);
      check("rst_score", 64'(bus.out_score), 64'd0);
      check("rst_img", 64'(img_count), 64'd0);
      check("rst_ovf", 64'(err_overflow), 64'd0);
      check("rst_bdrop", 64'(err_busy_drop), 64'd0);
      check("rst_rd", 64'(rd_score), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Single winner, latency check
      v = fill(16'h0010);
      v[7*DATA_W +: DATA_W] = 16'h0300;
      strobe(v, 0);
      repeat (N-1) @(posedge clk);
      @(negedge clk);
      check("lat_early_valid", 64'(bus.out_valid), 64'd0);
      check("lat_busy", 64'(bus.busy), 64'd1);
      @(posedge clk);
      @(negedge clk);
      check("lat_valid", 64'(bus.out_valid), 64'd1);
      check("lat_idle", 64'(bus.busy), 64'd0);
      check("t1_img", 64'(img_count), 64'(exp_img));
      @(posedge clk); #1;
      drain();

      // All negative, -1 wins
      for (int k = 0; k < N; k++) v[k*DATA_W +: DATA_W] = 16'($urandom_range(32'h8000, 32'hFFFE));
      v[3*DATA_W +: DATA_W] = 16'hFFFF;
      send(v);
      drain();

      // Tie goes to the lower index; readback
      v = fill(16'h0000);
      v[2*DATA_W +: DATA_W] = 16'h0100;
      v[5*DATA_W +: DATA_W] = 16'h0100;
      send(v);
      rd_sel = 4'd5; #1;
      check("rd_sel5", 64'(rd_score), 64'h0100);
      rd_sel = 4'd0; #1;
      check("rd_sel0", 64'(rd_score), 64'h0);
      rd_sel = 4'd12; #1;
      check("rd_sel_oor", 64'(rd_score), 64'h0);
      drain();

      // Strobe while busy is dropped
      p0 = pops;
      v = fill(16'h0000);
      v[6*DATA_W +: DATA_W] = 16'h0500;
      v2 = fill(16'h0000);
      v2[8*DATA_W +: DATA_W] = 16'h0700;
      strobe(v, 0);
      repeat (3) @(posedge clk);
      #1;
      strobe(v2, 2);
      repeat (6) @(posedge clk);
      #1;
      check("bdrop_flag", 64'(err_busy_drop), 64'd1);
      rd_sel = 4'd8; #1;
      check("bdrop_latched", 64'(rd_score), 64'h0);
      drain();
      check("bdrop_entries", 64'(pops - p0), 64'd1);

      // Random images with random consumer backpressure
      rdy_mode = 1;
      for (int n = 0; n < 30; n++) begin
         for (int k = 0; k < N; k++) begin
            if (n % 3 == 0) v[k*DATA_W +: DATA_W] = 16'($signed($urandom_range(0, 4)) - 2);
            else            v[k*DATA_W +: DATA_W] = 16'($urandom);
         end
         send(v);
      end
      drain();
      check("rand_ovf", 64'(err_overflow), 64'd0);
      check("rand_img", 64'(img_count), 64'(exp_img));

      // Overflow: 17 images without draining
      for (int n = 0; n < DEPTH + 1; n++) begin
         for (int k = 0; k < N; k++) v[k*DATA_W +: DATA_W] = 16'($urandom_range(0, 32'h0FFF));
         v[1*DATA_W +: DATA_W] = 16'h7000;
         send(v);
      end
      @(negedge clk);
      check("ovf_flag", 64'(err_overflow), 64'd1);
      check("ovf_img", 64'(img_count), 64'(exp_img));
      check("ovf_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk); #1;

      // Push at full with a simultaneous pop
      p0 = pops;
      v = fill(16'h0001);
      v[4*DATA_W +: DATA_W] = 16'h7FFF;
      rdy_mode = 3;
      strobe(v, 1);
      repeat (8) @(posedge clk);
      @(negedge clk);
      rdy_manual = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rdy_manual = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("fullpop_img", 64'(img_count), 64'(exp_img));
      check("fullpop_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk); #1;
      drain();
      check("fullpop_entries", 64'(pops - p0), 64'(DEPTH + 1));

      // Reset in the middle of a scan
      strobe(fill(16'h0042), 2);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mrst_busy", 64'(bus.busy), 64'd0);
      check("mrst_valid", 64'(bus.out_valid), 64'd0);
      check("mrst_img", 64'(img_count), 64'd0);
      check("mrst_ovf", 64'(err_overflow), 64'd0);
      check("mrst_bdrop", 64'(err_busy_drop), 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (15) @(posedge clk);
      @(negedge clk);
      check("mrst_after_valid", 64'(bus.out_valid), 64'd0);
      check("mrst_after_img", 64'(img_count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
